// File: rtl/fixed_point_multiplier_seq.sv
// Sequential Q(WIDTH-FRAC).FRAC two's-complement multiplier: shift-add, truncate, saturate.
// Latency: done pulses WIDTH+1 clocks after the accepting edge; one product per WIDTH+2 cycles.
// Backpressure: none queued; start is honoured only in IDLE and ignored while busy.
module fixed_point_multiplier_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             busy,
    output logic             done
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int MAG_W = ACC_W - FRAC;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    // Largest positive magnitude and largest negative magnitude representable.
    localparam logic [MAG_W-1:0] POS_LIM   = MAG_W'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [MAG_W-1:0] NEG_LIM   = MAG_W'(64'd1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0] POS_SAT   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_SAT   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic               sign;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [ACC_W-1:0]   partial;
    logic [MAG_W-1:0]   mag_full;
    logic [WIDTH-1:0]   mag_lo;
    logic [WIDTH-1:0]   sat_result;
    logic               sat_ovf;

    // Operand magnitudes; the most negative value maps onto its own unsigned pattern.
    always_comb begin
        abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
        abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;
    end

    // Current shifted multiplicand for the bit of |B| under the counter.
    always_comb begin
        partial = {{WIDTH{1'b0}}, mag_a} << cnt;
    end

    // Truncate the magnitude toward zero, then saturate into the signed result range.
    always_comb begin
        mag_full   = acc[ACC_W-1:FRAC];
        mag_lo     = mag_full[WIDTH-1:0];
        sat_result = '0;
        sat_ovf    = 1'b0;
        if (mag_full == '0) begin
            sat_result = '0;
            sat_ovf    = 1'b0;
        end else if (!sign) begin
            if (mag_full > POS_LIM) begin
                sat_result = POS_SAT;
                sat_ovf    = 1'b1;
            end else begin
                sat_result = mag_lo;
            end
        end else begin
            if (mag_full > NEG_LIM) begin
                sat_result = NEG_SAT;
                sat_ovf    = 1'b1;
            end else begin
                sat_result = ~mag_lo + 1'b1;
            end
        end
    end

    // Control FSM plus datapath registers; outputs are registered and only move at FINISH or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sign          <= 1'b0;
            mag_a         <= '0;
            mag_b         <= '0;
            acc           <= '0;
            cnt           <= '0;
            result        <= '0;
            overflow_flag <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        sign  <= A[WIDTH-1] ^ B[WIDTH-1];
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mag_b[cnt]) begin
                        acc <= acc + partial;
                    end
                    if (cnt == LAST_ITER) begin
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    result        <= sat_result;
                    overflow_flag <= sat_ovf;
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_multiplier_seq.sv
// Directed bench for fixed_point_multiplier_seq: vector table plus handshake corner sequences.
// Latency: expects done 17 clocks after the accepting edge for WIDTH=16.
// Backpressure: exercises ignored start while busy, back-to-back and held start.
module tb_fixed_point_multiplier_seq;

    localparam int W   = 16;
    localparam int LAT = W + 1;
    localparam int MAX_WAIT = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] result;
    logic         overflow_flag;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[15];

    fixed_point_multiplier_seq #(.WIDTH(16), .FRAC(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .A            (A),
        .B            (B),
        .result       (result),
        .overflow_flag(overflow_flag),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ticks until done; lat counts edges after the accepting edge. busy_ok drops if busy ever reads 0.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < MAX_WAIT) begin
            tick();
            lat++;
            if (!busy) busy_ok = 1'b0;
            if (done) break;
        end
    endtask

    // Counts done pulses over n cycles.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eo);
        int lat;
        bit bok;
        start = 1'b1;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        wait_done(lat, bok);
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " ovf"}, 32'(overflow_flag), 32'(eo));
        chk({tag, " busy held"}, 32'(bok), 32'd1);
        tick();
        chk({tag, " done one-shot"}, 32'(done), 32'd0);
        chk({tag, " busy clear"}, 32'(busy), 32'd0);
        chk({tag, " result held"}, 32'(result), 32'(er));
    endtask

    initial begin
        int lat;
        int n;
        bit bok;

        vecs[0]  = '{16'h0180, 16'h0200, 16'h0300, 1'b0};
        vecs[1]  = '{16'hFE80, 16'h0200, 16'hFD00, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0};
        vecs[3]  = '{16'h4000, 16'h0200, 16'h7FFF, 1'b1};
        vecs[4]  = '{16'hFF00, 16'h8000, 16'h7FFF, 1'b1};
        vecs[5]  = '{16'hC000, 16'h0200, 16'h8000, 1'b0};
        vecs[6]  = '{16'h8000, 16'h0200, 16'h8000, 1'b1};
        vecs[7]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1};
        vecs[8]  = '{16'hFF00, 16'h0080, 16'hFF80, 1'b0};
        vecs[9]  = '{16'hFFFD, 16'h0155, 16'hFFFD, 1'b0};
        vecs[10] = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};
        vecs[11] = '{16'h7FFF, 16'hFF00, 16'h8001, 1'b0};
        vecs[12] = '{16'h0000, 16'h8000, 16'h0000, 1'b0};
        vecs[13] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[14] = '{16'h0080, 16'h0080, 16'h0040, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        chk("reset result", 32'(result), 32'd0);
        chk("reset ovf", 32'(overflow_flag), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_ovf);
        end

        // Second start while running is ignored; the single done carries the first product.
        start = 1'b1; A = 16'h0180; B = 16'h0200;
        tick();
        start = 1'b0; A = '0; B = '0;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1; A = 16'h4000; B = 16'h0200;
        tick();
        start = 1'b0;
        wait_done(lat, bok);
        chk("ignored start latency", 32'(lat + 5), 32'(LAT));
        chk("ignored start result", 32'(result), 32'h0300);
        chk("ignored start ovf", 32'(overflow_flag), 32'd0);

        // Back-to-back: start in the done cycle is accepted on the next edge.
        start = 1'b1; A = 16'hFE80; B = 16'h0200;
        tick();
        start = 1'b0; A = '0; B = '0;
        chk("b2b accept busy", 32'(busy), 32'd1);
        chk("b2b done low", 32'(done), 32'd0);
        chk("b2b result held", 32'(result), 32'h0300);
        wait_done(lat, bok);
        chk("b2b latency", 32'(lat), 32'(LAT));
        chk("b2b result", 32'(result), 32'hFD00);
        chk("b2b busy held", 32'(bok), 32'd1);
        count_done(25, n);
        chk("b2b no extra done", 32'(n), 32'd0);

        // Reset mid-run aborts with no done; outputs return to reset values.
        start = 1'b1; A = 16'h0180; B = 16'h0200;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort result", 32'(result), 32'd0);
        chk("abort ovf", 32'(overflow_flag), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        count_done(25, n);
        chk("abort no done", 32'(n), 32'd0);
        run_op("after abort", 16'h0180, 16'h0200, 16'h0300, 1'b0);

        // rst wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; A = 16'h0100; B = 16'h0100;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst+start busy", 32'(busy), 32'd0);
        count_done(25, n);
        chk("rst+start no done", 32'(n), 32'd0);

        // Held start: a new operation each time IDLE is reached, one per W+2 cycles.
        start = 1'b1; A = 16'h0100; B = 16'h0300;
        tick();
        wait_done(lat, bok);
        chk("held first latency", 32'(lat), 32'(LAT));
        chk("held first result", 32'(result), 32'h0300);
        A = 16'hFF00; B = 16'h0300;
        tick();
        chk("held reaccept busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat, bok);
        chk("held second latency", 32'(lat), 32'(LAT));
        chk("held second result", 32'(result), 32'hFD00);
        tick();
        chk("held final busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_point_multiplier_seq.md
# fixed_point_multiplier_seq

Sequential two's-complement fixed-point multiplier for the ODE accelerator datapath, placed directly upstream of the fixed-point adder. It forms the scaled increment term (e.g. h·f(t,y)) that the adder combines with the state value. Each product is computed by an iterative shift-add over WIDTH cycles, then truncated to the fixed-point format and saturated. The result and an overflow flag are presented in the same A/B → result/overflow_flag shape the adder uses, plus a start/done handshake.

## Interface
- WIDTH, 16: operand and result width; also the number of shift-add iterations.
- FRAC, 8: number of fractional bits in operands and result (Q(WIDTH-FRAC).FRAC).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only while idle.
- A  in  WIDTH  multiplicand, two's complement fixed point.
- B  in  WIDTH  multiplier, two's complement fixed point.
- result  out  WIDTH  saturated product; held until the next done.
- overflow_flag  out  1  1 when result was saturated; held with result.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result and overflow_flag are valid from this cycle.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE with start=1:
  - latch sign = A[W-1]^B[W-1], |A| and |B| as W-bit unsigned magnitudes (|0x8000| = 0x8000);
  - clear the 2W-bit accumulator and the iteration counter;
  - go to RUN.
- RUN: each edge processes one bit of |B|, LSB first.
  - If the bit is 1, add the shifted |A| into the accumulator.
  - After the W-th iteration (counter == W-1), go to FINISH.
- FINISH:
  - mag = accumulator >> FRAC (truncation toward zero on magnitude).
  - Positive result: if mag > 2^(W-1)-1, result = 0x7FFF and overflow_flag = 1; else result = mag and overflow_flag = 0.
  - Negative result: if mag > 2^(W-1), result = 0x8000 and overflow_flag = 1; else result = -mag and overflow_flag = 0.
  - A zero magnitude always gives result 0 with overflow_flag 0, whatever the sign.
  - Assert done, return to IDLE.
- start while busy (RUN/FINISH): ignored; no queuing.
- A and B may change freely after the start edge.

## Timing
- Reset values: result=0, overflow_flag=0, busy=0, done=0, state=IDLE, counter=0, accumulator=0.
- Start accepted at edge e0. Iterations occur at edges e1..eW. FINISH updates outputs at edge eW+1.
- Latency: done is high for exactly one cycle, W+1 clocks after the accepting edge (17 for W=16).
- busy is high after e0 through the cycle in which done is high; busy=0 thereafter.
- Back-to-back: start may be high in the cycle right after done; it is accepted at that edge (IDLE). Throughput is one product per W+2 cycles.
- start held continuously: a new operation is accepted each time IDLE is reached.
- rst mid-operation: aborts the operation; all outputs return to reset values at that edge; no done is produced.
- rst and start together: rst wins.
- result and overflow_flag change only at a FINISH edge or at reset.

## Test plan
- FRAC=8, A=0x0180 (1.5), B=0x0200 (2.0), pulse start → done exactly 17 cycles later, result=0x0300, overflow_flag=0; busy high for cycles 1..17.
- A=0xFE80 (-1.5), B=0x0200 → result=0xFD00, overflow_flag=0. A=0xFFFF (-1 LSB), B=0x0080 (0.5) → result=0x0000 (truncation toward zero), overflow_flag=0.
- A=0x4000 (64.0), B=0x0200 → result=0x7FFF, overflow_flag=1. A=0xFF00 (-1.0), B=0x8000 (-128.0) → result=0x7FFF, overflow_flag=1.
- A=0xC000 (-64.0), B=0x0200 → result=0x8000, overflow_flag=0 (exact most-negative value, no saturation).
- Start a product, pulse start again at cycle 5 with different operands → ignored; the single done carries the first product. A start on the cycle after done is accepted.
- Assert rst at cycle 8 of a RUN → no done pulse; result=0, overflow_flag=0, busy=0 on the next cycle. A fresh start afterwards completes normally in 17 cycles.
